// File: rtl/apb4_pkg.sv
// Shared types and width helpers for the APB4 requester bridge.
package apb4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   typedef enum logic [1:0] {
      RSP_OKAY    = 2'b00,
      RSP_SLVERR  = 2'b01,
      RSP_DECERR  = 2'b10,
      RSP_TIMEOUT = 2'b11
   } rsp_err_e;

   // Width of the slave index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Width of the ACCESS wait counter, which only needs to reach t-1.
   function automatic int cnt_width(input int t);
      return (t <= 2) ? 1 : $clog2(t);
   endfunction

endpackage

// File: rtl/apb4_slave_mux.sv
// Picks PRDATA/PREADY/PSLVERR of the addressed slave; all others are ignored.
module apb4_slave_mux #(
   parameter int DATA_WIDTH = 32,
   parameter int NO_SLAVES  = 4,
   parameter int IDX_W      = 2
) (
   input  logic [IDX_W-1:0]              idx,
   input  logic [NO_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NO_SLAVES-1:0]          pready,
   input  logic [NO_SLAVES-1:0]          pslverr,
   output logic [DATA_WIDTH-1:0]         sel_rdata,
   output logic                          sel_ready,
   output logic                          sel_slverr
);

   // Slice selection by index; out-of-range index yields all zeros.
   always_comb begin
      sel_rdata  = '0;
      sel_ready  = 1'b0;
      sel_slverr = 1'b0;
      for (int i = 0; i < NO_SLAVES; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_rdata  = prdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_ready  = pready[i];
            sel_slverr = pslverr[i];
         end
      end
   end

endmodule

// File: rtl/apb4_multi_master_bridge.sv
// APB4 requester: one command at a time from a valid/ready channel is turned
// into a SETUP/ACCESS transfer to the decoded slave; the result is returned
// on a registered valid/ready response channel.
// Handshake: a beat moves on a clock edge where valid && ready; once valid is
// raised it and its payload stay stable until ready is seen.
module apb4_multi_master_bridge
   import apb4_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int NO_SLAVES       = 4,
   parameter int SLAVE_ADDR_BITS = 12,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                            PCLK,
   input  logic                            PRESETn,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [ADDR_WIDTH-1:0]           cmd_addr,
   input  logic [DATA_WIDTH-1:0]           cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]         cmd_strb,
   input  logic [2:0]                      cmd_prot,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic [1:0]                      rsp_err,
   output logic [NO_SLAVES-1:0]            PSELx,
   output logic                            PENABLE,
   output logic [ADDR_WIDTH-1:0]           PADDR,
   output logic                            PWRITE,
   output logic [DATA_WIDTH-1:0]           PWDATA,
   output logic [DATA_WIDTH/8-1:0]         PSTRB,
   output logic [2:0]                      PPROT,
   input  logic [NO_SLAVES*DATA_WIDTH-1:0] PRDATA,
   input  logic [NO_SLAVES-1:0]            PREADY,
   input  logic [NO_SLAVES-1:0]            PSLVERR,
   output apb_state_e                      dbg_state
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = idx_width(NO_SLAVES);
   localparam int CNT_W  = cnt_width(TIMEOUT_CYCLES);
   localparam logic [IDX_W:0]   NSL     = (IDX_W+1)'(NO_SLAVES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit               TO_EN   = (TIMEOUT_CYCLES > 0);

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_W-1:0]     strb;
      logic [2:0]            prot;
   } cmd_t;

   apb_state_e            state_q, state_d;
   cmd_t                  cmd_q, cmd_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NO_SLAVES-1:0]  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   rsp_err_e              rsp_err_q, rsp_err_d;

   logic [IDX_W-1:0]      addr_idx;
   logic                  dec_err;
   logic [DATA_WIDTH-1:0] sel_rdata;
   logic                  sel_ready;
   logic                  sel_slverr;
   logic                  timeout_hit;

   assign addr_idx    = cmd_addr[SLAVE_ADDR_BITS +: IDX_W];
   assign dec_err     = ({1'b0, addr_idx} >= NSL);
   assign timeout_hit = TO_EN && !sel_ready && (cnt_q == CNT_MAX);

   apb4_slave_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .NO_SLAVES  (NO_SLAVES),
      .IDX_W      (IDX_W)
   ) u_slave_mux (
      .idx        (idx_q),
      .prdata     (PRDATA),
      .pready     (PREADY),
      .pslverr    (PSLVERR),
      .sel_rdata  (sel_rdata),
      .sel_ready  (sel_ready),
      .sel_slverr (sel_slverr)
   );

   // State register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; PREADY on the expiry cycle takes priority over timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (cmd_valid) state_d = dec_err ? ST_RESP : ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (sel_ready || timeout_hit) state_d = ST_RESP;
         ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Next values of the command register, bus controls and response.
   always_comb begin
      cmd_d       = cmd_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               cmd_d.write = cmd_write;
               cmd_d.addr  = cmd_addr;
               cmd_d.wdata = cmd_wdata;
               cmd_d.strb  = cmd_write ? cmd_strb : '0;
               cmd_d.prot  = cmd_prot;
               idx_d       = addr_idx;
               if (dec_err) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = RSP_DECERR;
                  rsp_rdata_d = '0;
               end else begin
                  penable_d = 1'b0;
                  for (int i = 0; i < NO_SLAVES; i++) psel_d[i] = (addr_idx == IDX_W'(i));
               end
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ST_ACCESS: begin
            if (sel_ready) begin
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = sel_slverr ? RSP_SLVERR : RSP_OKAY;
               rsp_rdata_d = (!cmd_q.write && !sel_slverr) ? sel_rdata : '0;
            end else if (timeout_hit) begin
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = RSP_TIMEOUT;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cmd_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= RSP_OKAY;
      end else begin
         cmd_q       <= cmd_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign PSELx     = psel_q;
   assign PENABLE   = penable_q;
   assign PADDR     = cmd_q.addr;
   assign PWRITE    = cmd_q.write;
   assign PWDATA    = cmd_q.wdata;
   assign PSTRB     = cmd_q.strb;
   assign PPROT     = cmd_q.prot;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_apb4_multi_master_bridge.sv
// Directed bench for the APB4 requester bridge: a 4-slave instance with an
// 8-cycle timeout, plus a 3-slave instance for address decode errors.
module tb_apb4_multi_master_bridge;
   import apb4_pkg::*;

   // ---------------- clock / reset ----------------
   logic pclk = 1'b0;
   logic presetn;
   always #5 pclk = ~pclk;

   // ---------------- 4-slave DUT ----------------
   logic         cmd_valid, cmd_ready, cmd_write;
   logic [31:0]  cmd_addr, cmd_wdata;
   logic [3:0]   cmd_strb;
   logic [2:0]   cmd_prot;
   logic         rsp_valid, rsp_ready;
   logic [31:0]  rsp_rdata;
   logic [1:0]   rsp_err;
   logic [3:0]   psel;
   logic         penable, pwrite;
   logic [31:0]  paddr, pwdata;
   logic [3:0]   pstrb;
   logic [2:0]   pprot;
   logic [127:0] prdata;
   logic [3:0]   pready, pslverr;
   apb_state_e   dbg_state;

   apb4_multi_master_bridge #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NO_SLAVES(4),
      .SLAVE_ADDR_BITS(12), .TIMEOUT_CYCLES(8)
   ) u_dut (
      .PCLK(pclk), .PRESETn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSELx(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
      .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
      .dbg_state(dbg_state)
   );

   // ---------------- 3-slave DUT ----------------
   logic         cmd3_valid, cmd3_ready;
   logic [31:0]  cmd3_addr;
   logic         rsp3_valid, rsp3_ready;
   logic [31:0]  rsp3_rdata;
   logic [1:0]   rsp3_err;
   logic [2:0]   psel3;
   logic         penable3, pwrite3;
   logic [31:0]  paddr3, pwdata3;
   logic [3:0]   pstrb3;
   logic [2:0]   pprot3;
   logic [95:0]  prdata3;
   logic [2:0]   pready3, pslverr3;
   apb_state_e   dbg_state3;

   apb4_multi_master_bridge #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NO_SLAVES(3),
      .SLAVE_ADDR_BITS(12), .TIMEOUT_CYCLES(256)
   ) u_dut3 (
      .PCLK(pclk), .PRESETn(presetn),
      .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready), .cmd_write(1'b0),
      .cmd_addr(cmd3_addr), .cmd_wdata(32'h0), .cmd_strb(4'h0), .cmd_prot(3'h0),
      .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_rdata(rsp3_rdata), .rsp_err(rsp3_err),
      .PSELx(psel3), .PENABLE(penable3), .PADDR(paddr3), .PWRITE(pwrite3), .PWDATA(pwdata3),
      .PSTRB(pstrb3), .PPROT(pprot3), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
      .dbg_state(dbg_state3)
   );

   // ---------------- scoreboard ----------------
   int          n_chk = 0;
   int          n_bad = 0;
   logic [33:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // One full transfer on the 4-slave DUT. waits<0 means the slave never
   // answers. Unaddressed slaves are parked ready/erroring with junk data.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int slv,
                       input int waits, input logic slverr, input logic [31:0] rd,
                       input int exp_acc, input logic [1:0] exp_err,
                       input logic [31:0] exp_rdata, input int hold);
      int          n_acc;
      logic [33:0] exp;
      logic [3:0]  exp_sel;
      exp_sel = 4'b0001 << slv;
      exp_q.push_back({exp_err, exp_rdata});
      for (int i = 0; i < 4; i++) begin
         if (i == slv) begin
            pready[i] = 1'b0; pslverr[i] = slverr; prdata[i*32 +: 32] = rd;
         end else begin
            pready[i] = 1'b1; pslverr[i] = 1'b1; prdata[i*32 +: 32] = 32'hBAD0_0000 + i;
         end
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
      cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
      check("idle_cmd_ready", cmd_ready, 1);
      @(posedge pclk); #1;
      cmd_valid = 1'b0;
      // SETUP
      check("setup_psel",    psel,    exp_sel);
      check("setup_penable", penable, 0);
      check("setup_paddr",   paddr,   addr);
      check("setup_pwrite",  pwrite,  wr);
      check("setup_pwdata",  pwdata,  wdata);
      check("setup_pstrb",   pstrb,   wr ? strb : 4'h0);
      check("setup_pprot",   pprot,   prot);
      check("setup_cmd_ready", cmd_ready, 0);
      check("setup_rsp_valid", rsp_valid, 0);
      @(posedge pclk); #1;
      // ACCESS
      n_acc = 0;
      while (penable && n_acc < 50) begin
         check("access_psel",  psel,  exp_sel);
         check("access_paddr", paddr, addr);
         check("access_pstrb", pstrb, wr ? strb : 4'h0);
         pready[slv] = (waits >= 0) && (n_acc >= waits);
         @(posedge pclk); #1;
         n_acc++;
      end
      pready[slv] = 1'b0;
      check("access_cycles", n_acc, exp_acc);
      // RESP
      exp = exp_q.pop_front();
      check("resp_psel",  psel, 0);
      check("resp_valid", rsp_valid, 1);
      check("resp_err",   rsp_err,   exp[33:32]);
      check("resp_rdata", rsp_rdata, exp[31:0]);
      check("resp_cmd_ready", cmd_ready, 0);
      for (int c = 0; c < hold; c++) begin
         @(posedge pclk); #1;
         check("hold_valid",     rsp_valid, 1);
         check("hold_err",       rsp_err,   exp[33:32]);
         check("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge pclk); #1;
      rsp_ready = 1'b0;
      check("done_valid",     rsp_valid, 0);
      check("done_cmd_ready", cmd_ready, 1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      presetn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
      prdata = '0; pready = '0; pslverr = '0;
      cmd3_valid = 1'b0; cmd3_addr = '0; rsp3_ready = 1'b0;
      prdata3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      pready3 = 3'b111; pslverr3 = 3'b000;

      // Reset values
      repeat (3) @(posedge pclk);
      #1;
      check("rst_psel",      psel,      0);
      check("rst_penable",   penable,   0);
      check("rst_paddr",     paddr,     0);
      check("rst_pwdata",    pwdata,    0);
      check("rst_pstrb",     pstrb,     0);
      check("rst_pwrite",    pwrite,    0);
      check("rst_pprot",     pprot,     0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err",   rsp_err,   0);
      presetn = 1'b1;
      @(posedge pclk); #1;
      check("rel_cmd_ready", cmd_ready, 1);
      check("rel_state",     dbg_state, ST_IDLE);

      // Zero-wait write to slave 1
      xfer(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 3'b000, 1, 0, 1'b0, 32'h0,
           1, 2'b00, 32'h0, 0);
      // Read from slave 2 with 3 wait states; strobes must be dropped
      xfer(1'b0, 32'h0000_2004, 32'h1234_5678, 4'hF, 3'b010, 2, 3, 1'b0, 32'hCAFE_F00D,
           4, 2'b00, 32'hCAFE_F00D, 0);
      // Read from slave 3 answering with PSLVERR
      xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b001, 3, 0, 1'b1, 32'h1234_5678,
           1, 2'b01, 32'h0, 0);
      // Partial-strobe write to slave 1 that errors after one wait
      xfer(1'b1, 32'h0000_1FFC, 32'hA5A5_5A5A, 4'h5, 3'b101, 1, 1, 1'b1, 32'hFFFF_FFFF,
           2, 2'b01, 32'h0, 0);
      // Slave 0 never ready: abort after 8 ACCESS cycles, response held 5 cycles
      xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000, 0, -1, 1'b0, 32'h7777_7777,
           8, 2'b11, 32'h0, 5);
      // PREADY on the expiry cycle wins over the timeout
      xfer(1'b0, 32'h0000_0080, 32'h0, 4'h0, 3'b000, 0, 7, 1'b0, 32'h0BAD_CAFE,
           8, 2'b00, 32'h0BAD_CAFE, 0);

      // Decode error on the 3-slave instance: no PSEL, response one cycle after accept
      cmd3_valid = 1'b1; cmd3_addr = 32'h0000_3000;
      check("dec_cmd_ready", cmd3_ready, 1);
      @(posedge pclk); #1;
      cmd3_valid = 1'b0;
      check("dec_psel",      psel3,      0);
      check("dec_penable",   penable3,   0);
      check("dec_rsp_valid", rsp3_valid, 1);
      check("dec_rsp_err",   rsp3_err,   2'b10);
      check("dec_rsp_rdata", rsp3_rdata, 0);
      check("dec_cmd_busy",  cmd3_ready, 0);
      rsp3_ready = 1'b1;
      @(posedge pclk); #1;
      rsp3_ready = 1'b0;
      check("dec_done_valid", rsp3_valid, 0);
      check("dec_done_ready", cmd3_ready, 1);

      // Reset in the middle of an ACCESS phase
      pready = 4'b0000; pslverr = 4'b0000;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_1000;
      cmd_wdata = 32'h5555_AAAA; cmd_strb = 4'hF; cmd_prot = 3'b000;
      @(posedge pclk); #1;
      cmd_valid = 1'b0;
      @(posedge pclk); #1;
      check("mid_penable", penable, 1);
      #2 presetn = 1'b0;
      #1;
      check("mid_rst_psel",      psel,      0);
      check("mid_rst_penable",   penable,   0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_paddr",     paddr,     0);
      @(posedge pclk); #1;
      presetn = 1'b1;
      @(posedge pclk); #1;
      check("mid_rel_cmd_ready", cmd_ready, 1);
      check("mid_rel_rsp_valid", rsp_valid, 0);
      xfer(1'b1, 32'h0000_2010, 32'h0102_0304, 4'h3, 3'b011, 2, 0, 1'b0, 32'h0,
           1, 2'b00, 32'h0, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
